// File: rtl/tdm_demux4_pkg.sv
// Shared types and constants for the 4-channel TDM demultiplexer.
// The slot index is 2 bits, so the channel count is fixed at 4.
package tdm_demux4_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam int SLOT_W = 2;
  localparam int NCH    = 4;

endpackage

// File: rtl/tdm_demux4_slot_ctr.sv
// Slot counter for the TDM demultiplexer.
// Holds the next expected slot index. Priority is clear, then load-to-1, then increment.
module tdm_demux4_slot_ctr
  import tdm_demux4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot
);

  logic [SLOT_W-1:0] slot_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg <= '0;
    end else if (clr) begin
      slot_reg <= '0;
    end else if (load1) begin
      slot_reg <= SLOT_W'(1);
    end else if (inc) begin
      slot_reg <= slot_reg + 1'b1;   // 3 wraps to 0
    end
  end

  assign slot = slot_reg;

endmodule

// File: rtl/tdm_demux4.sv
// Receive-side TDM demultiplexer. It collects four slot samples, starting at the
// beat marked by in_sync, and presents them as one registered frame-aligned word.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sync,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 err_clr,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic [SLOT_W-1:0]    slot,
  output logic                 locked,
  output logic                 sync_err
);

  state_t                 state_reg;
  logic [SLOT_W-1:0]      slot_cur;
  logic [NCH*WIDTH-1:0]   out_data_reg;
  logic                   out_valid_reg;
  logic                   sync_err_reg;
  logic [3*WIDTH-1:0]     shadow;
  logic [2:0]             shadow_we;

  logic ctr_inc;
  logic ctr_load1;
  logic ctr_clr;
  logic in_lock;
  logic at_slot0;
  logic frame_done;
  logic err_set;
  logic lose_lock;

  assign in_lock  = (state_reg == ST_LOCK);
  assign at_slot0 = (slot_cur == '0);

  always_comb begin
    ctr_inc    = 1'b0;
    ctr_load1  = 1'b0;
    ctr_clr    = 1'b0;
    shadow_we  = '0;
    frame_done = 1'b0;
    err_set    = 1'b0;
    lose_lock  = 1'b0;
    if (in_valid) begin
      if (in_sync) begin
        // A sync beat always starts a frame, whether hunting, on time or early.
        ctr_load1    = 1'b1;
        shadow_we[0] = 1'b1;
        err_set      = in_lock && !at_slot0;
      end else if (in_lock) begin
        if (at_slot0) begin
          ctr_clr   = 1'b1;
          err_set   = 1'b1;
          lose_lock = 1'b1;
        end else begin
          ctr_inc = 1'b1;
          if (slot_cur == SLOT_W'(1)) shadow_we[1] = 1'b1;
          if (slot_cur == SLOT_W'(2)) shadow_we[2] = 1'b1;
          frame_done = (slot_cur == SLOT_W'(3));
        end
      end
    end
  end

  tdm_demux4_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctr_inc),
    .load1 (ctr_load1),
    .clr   (ctr_clr),
    .slot  (slot_cur)
  );

  // Slot 3 is never stored; it goes straight into the output word.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_shadow
      logic [WIDTH-1:0] val_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          val_reg <= '0;
        end else if (shadow_we[gi]) begin
          val_reg <= in_data;
        end
      end

      assign shadow[gi*WIDTH +: WIDTH] = val_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_HUNT;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
    end else begin
      out_valid_reg <= frame_done;
      if (frame_done) begin
        out_data_reg <= {in_data, shadow};
      end

      if (in_valid && in_sync) begin
        state_reg <= ST_LOCK;
      end else if (lose_lock) begin
        state_reg <= ST_HUNT;
      end

      // A new error takes precedence over a simultaneous clear.
      if (err_set) begin
        sync_err_reg <= 1'b1;
      end else if (err_clr) begin
        sync_err_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign slot      = slot_cur;
  assign locked    = in_lock;
  assign sync_err  = sync_err_reg;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: a constant vector table, a pattern sweep,
// a randomized run against a queue-based frame model, and reset corner cases.
module tb_tdm_demux4;

  localparam int W = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_sync;
  logic [W-1:0]   in_data;
  logic           err_clr;
  logic [4*W-1:0] out_data;
  logic           out_valid;
  logic [1:0]     slot;
  logic           locked;
  logic           sync_err;

  int n_checks = 0;
  int n_errors = 0;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .in_data   (in_data),
    .err_clr   (err_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .slot      (slot),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  // The reference model keeps the samples gathered since the last sync in a queue.
  logic [W-1:0]   q[$];
  bit             m_locked;
  logic [4*W-1:0] m_data;
  bit             m_valid;
  bit             m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_locked = 1'b0;
    m_data   = '0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_beat(input bit v, input bit s, input logic [W-1:0] d, input bit clr);
    bit err;
    err     = 1'b0;
    m_valid = 1'b0;
    if (v) begin
      if (s) begin
        if (m_locked && q.size() != 0) err = 1'b1;
        q.delete();
        q.push_back(d);
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (q.size() == 0) begin
          err      = 1'b1;
          m_locked = 1'b0;
        end else begin
          q.push_back(d);
          if (q.size() == 4) begin
            m_data = '0;
            for (int k = 0; k < 4; k++) m_data |= (4*W)'(q[k]) << (k*W);
            m_valid = 1'b1;
            q.delete();
          end
        end
      end
    end
    if (err) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic compare_model();
    check("model_out_data", 32'(out_data), 32'(m_data));
    check("model_out_valid", 32'(out_valid), 32'(m_valid));
    check("model_slot", 32'(slot), 32'(q.size()));
    check("model_locked", 32'(locked), 32'(m_locked));
    check("model_sync_err", 32'(sync_err), 32'(m_err));
  endtask

  // Called at posedge+1; drives one cycle and samples at the following posedge+1.
  task automatic step(input bit v, input bit s, input logic [W-1:0] d, input bit clr);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    err_clr  = clr;
    @(posedge clk);
    model_beat(v, s, d, clr);
    #1;
    compare_model();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_slot"}, 32'(slot), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_sync_err"}, 32'(sync_err), 32'd0);
  endtask

  typedef struct {
    bit       v;
    bit       s;
    bit       d;
    bit       clr;
    bit       e_valid;
    bit [3:0] e_data;
    bit [1:0] e_slot;
    bit       e_locked;
    bit       e_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Frame {1,0,1,1} twice, back to back.
    vecs.push_back('{1,1,1,0, 0,4'b0000,2'd1,1,0});
    vecs.push_back('{1,0,0,0, 0,4'b0000,2'd2,1,0});
    vecs.push_back('{1,0,1,0, 0,4'b0000,2'd3,1,0});
    vecs.push_back('{1,0,1,0, 1,4'b1101,2'd0,1,0});
    vecs.push_back('{1,1,1,0, 0,4'b1101,2'd1,1,0});
    vecs.push_back('{1,0,0,0, 0,4'b1101,2'd2,1,0});
    vecs.push_back('{1,0,1,0, 0,4'b1101,2'd3,1,0});
    vecs.push_back('{1,0,1,0, 1,4'b1101,2'd0,1,0});
    // Early sync on slot 2 restarts the frame and flags an error.
    vecs.push_back('{1,1,0,0, 0,4'b1101,2'd1,1,0});
    vecs.push_back('{1,0,1,0, 0,4'b1101,2'd2,1,0});
    vecs.push_back('{1,1,1,0, 0,4'b1101,2'd1,1,1});
    vecs.push_back('{1,0,0,0, 0,4'b1101,2'd2,1,1});
    vecs.push_back('{1,0,0,0, 0,4'b1101,2'd3,1,1});
    vecs.push_back('{1,0,1,0, 1,4'b1001,2'd0,1,1});
    vecs.push_back('{0,0,0,1, 0,4'b1001,2'd0,1,0});
    // Missing sync at slot 0: lose lock, drop beats until the next sync.
    vecs.push_back('{1,0,1,0, 0,4'b1001,2'd0,0,1});
    vecs.push_back('{1,0,1,0, 0,4'b1001,2'd0,0,1});
    vecs.push_back('{1,1,0,1, 0,4'b1001,2'd1,1,0});
    vecs.push_back('{1,0,1,0, 0,4'b1001,2'd2,1,0});
    // Three stall cycles between slot 1 and slot 2.
    vecs.push_back('{0,0,0,0, 0,4'b1001,2'd2,1,0});
    vecs.push_back('{0,1,1,0, 0,4'b1001,2'd2,1,0});
    vecs.push_back('{0,0,0,0, 0,4'b1001,2'd2,1,0});
    vecs.push_back('{1,0,1,0, 0,4'b1001,2'd3,1,0});
    vecs.push_back('{1,0,0,0, 1,4'b0110,2'd0,1,0});
    // Missing sync together with err_clr: the error wins.
    vecs.push_back('{1,0,0,1, 0,4'b0110,2'd0,0,1});
  end

  initial begin
    bit       v;
    bit       s;
    bit [3:0] p;

    // Reset held with random inputs.
    rst_n    = 1'b0;
    in_valid = 1'($urandom);
    in_sync  = 1'($urandom);
    in_data  = W'($urandom);
    err_clr  = 1'($urandom);
    #15;
    check_all_zero("reset");
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_data  = '0;
    err_clr  = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    $display("reset released: out_data=%0h locked=%0b", out_data, locked);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].s, W'(vecs[i].d), vecs[i].clr);
      check("vec_out_valid", 32'(out_valid), 32'(vecs[i].e_valid));
      check("vec_out_data", 32'(out_data), 32'(vecs[i].e_data));
      check("vec_slot", 32'(slot), 32'(vecs[i].e_slot));
      check("vec_locked", 32'(locked), 32'(vecs[i].e_locked));
      check("vec_sync_err", 32'(sync_err), 32'(vecs[i].e_err));
      $display("vec %0d: v=%0b s=%0b d=%0b clr=%0b -> data=%0h valid=%0b slot=%0d lock=%0b err=%0b",
               i, vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].clr,
               out_data, out_valid, slot, locked, sync_err);
    end

    // Sweep all 16 patterns; channel k must carry pattern bit k.
    for (int pi = 0; pi < 16; pi++) begin
      p = 4'(pi);
      step(1'b1, 1'b1, W'(p[0]), 1'b0);
      step(1'b1, 1'b0, W'(p[1]), 1'b0);
      step(1'b1, 1'b0, W'(p[2]), 1'b0);
      step(1'b1, 1'b0, W'(p[3]), 1'b0);
      check("sweep_valid", 32'(out_valid), 32'd1);
      check("sweep_data", 32'(out_data), 32'(p));
      $display("sweep pattern=%0h -> out_data=%0h valid=%0b", p, out_data, out_valid);
    end

    // Randomized run, mostly well-formed with occasional framing faults.
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) < 8);
      s = (q.size() == 0) && m_locked;
      if (!m_locked) s = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) s = ~s;
      step(v, s, W'($urandom), ($urandom_range(0, 19) == 0));
      $display("rand %0d: v=%0b s=%0b -> data=%0h valid=%0b slot=%0d lock=%0b err=%0b",
               i, v, s, out_data, out_valid, slot, locked, sync_err);
    end

    // Reset mid-frame: outputs clear at once, without waiting for a clock.
    step(1'b1, 1'b1, W'(1), 1'b0);
    step(1'b1, 1'b0, W'(1), 1'b0);
    in_valid = 1'b0;
    in_sync  = 1'b0;
    err_clr  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    compare_model();
    $display("mid-frame reset: out_data=%0h slot=%0d locked=%0b", out_data, slot, locked);
    step(1'b1, 1'b1, W'(0), 1'b0);
    step(1'b1, 1'b0, W'(1), 1'b0);
    step(1'b1, 1'b0, W'(1), 1'b0);
    step(1'b1, 1'b0, W'(0), 1'b0);
    check("postreset_data", 32'(out_data), 32'h6);
    check("postreset_valid", 32'(out_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
